ppu_sparse_encoder: RTL and testbench



---
 rtl/ppu_pkg.sv | 29 ++
 rtl/ppu_quantize.sv | 27 ++
 rtl/ppu_sparse_encoder.sv | 174 +++++++++++++++++
 tb/tb_ppu_sparse_encoder.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// Shared types for the PPU sparse output encoder.
//   bitwidth_e  : clip width select (8/4/2/1 bits)
//   enc_state_e : encoder FSM states
//   clip_max()  : largest representable value for a given clip width
package ppu_pkg;

  typedef enum logic [1:0] {
    BW8 = 2'd0,
    BW4 = 2'd1,
    BW2 = 2'd2,
    BW1 = 2'd3
  } bitwidth_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } enc_state_e;

  function automatic logic [7:0] clip_max(input bitwidth_e bw);
    case (bw)
      BW8:     return 8'hFF;
      BW4:     return 8'h0F;
      BW2:     return 8'h03;
      default: return 8'h01;
    endcase
  endfunction

endpackage

// File: rtl/ppu_quantize.sv
// Combinational ReLU + saturating clip of one accumulator value.
//   in_data  : signed accumulator value
//   bitwidth : clip width select (bitwidth_e encoding)
//   q        : unsigned result, 0 .. 2**n-1
module ppu_quantize
  import ppu_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 8
) (
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            bitwidth,
  output logic [OUT_WIDTH-1:0]  q
);

  logic [DATA_WIDTH-1:0] max_ext;

  always_comb begin
    max_ext = DATA_WIDTH'(clip_max(bitwidth_e'(bitwidth)));
    // Sign bit set means negative: ReLU forces zero. Otherwise the value is
    // non-negative, so an unsigned compare against the clip limit is exact.
    if (in_data[DATA_WIDTH-1])  q = '0;
    else if (in_data > max_ext) q = OUT_WIDTH'(max_ext);
    else                        q = OUT_WIDTH'(in_data);
  end

endmodule

// File: rtl/ppu_sparse_encoder.sv
// PPU output path: quantises the accumulator readout stream and writes
// zero-run-length encoded (value, preceding-zero-count) pairs into OARAM.
//   clk, reset_n        : clock, synchronous active-low reset
//   bitwidth, start,
//   base_address        : group setup, sampled when start is taken in IDLE
//   in_valid/in_ready/
//   in_data/in_last     : element stream (accepted only in STREAM)
//   oaram_*             : registered write port, all zero when no write
//   busy, done          : FSM status; done pulses once per finished group
//   entry_count         : writes this group, saturates at 2**ADDR_W
//   overflow            : sticky, set when an emit found OARAM full
module ppu_sparse_encoder
  import ppu_pkg::*;
#(
  parameter int RAM_WIDTH   = 10,
  parameter int INDEX_WIDTH = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             bitwidth,
  input  logic                   start,
  input  logic [RAM_WIDTH-2:0]   base_address,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_last,
  output logic [OUT_WIDTH-1:0]   oaram_value,
  output logic [INDEX_WIDTH-1:0] oaram_indices_value,
  output logic [RAM_WIDTH-2:0]   oaram_address,
  output logic                   oaram_write_enable,
  output logic                   busy,
  output logic                   done,
  output logic [RAM_WIDTH-1:0]   entry_count,
  output logic                   overflow
);

  localparam int ADDR_W = RAM_WIDTH - 1;
  localparam logic [INDEX_WIDTH-1:0] MAX_RUN = '1;

  enc_state_e             state_q, state_d;
  logic [1:0]             bw_q, bw_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [INDEX_WIDTH-1:0] run_q, run_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   we_q, we_d;
  logic [OUT_WIDTH-1:0]   val_q, val_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;

  logic                   accept;
  logic [OUT_WIDTH-1:0]   q;
  logic                   emit;
  logic [OUT_WIDTH-1:0]   emit_val;
  logic [INDEX_WIDTH-1:0] emit_idx;

  ppu_quantize #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_quant (
    .in_data  (in_data),
    .bitwidth (bw_q),
    .q        (q)
  );

  assign in_ready = (state_q == STREAM);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d  = state_q;
    bw_d     = bw_q;
    base_d   = base_q;
    run_d    = run_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    we_d     = 1'b0;
    val_d    = '0;
    idx_d    = '0;
    addr_d   = '0;
    emit     = 1'b0;
    emit_val = '0;
    emit_idx = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          bw_d    = bitwidth;
          base_d  = base_address;
          run_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end

      STREAM: begin
        if (accept) begin
          if (q != '0) begin
            emit     = 1'b1;
            emit_val = q;
            emit_idx = run_q;
            run_d    = '0;
          end else if (run_q == MAX_RUN) begin
            // Run index saturated: spend an entry on a zero-valued filler so
            // the following value's index stays representable.
            emit     = 1'b1;
            emit_idx = MAX_RUN;
            run_d    = '0;
          end else begin
            run_d = run_q + INDEX_WIDTH'(1);
          end

          // count_q MSB set means every OARAM slot of this group is used.
          if (emit) begin
            if (count_q[ADDR_W]) begin
              ovf_d = 1'b1;
            end else begin
              we_d    = 1'b1;
              val_d   = emit_val;
              idx_d   = emit_idx;
              addr_d  = base_q + count_q[ADDR_W-1:0];
              count_d = count_q + (ADDR_W+1)'(1);
            end
          end

          if (in_last) state_d = FINISH;
        end
      end

      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bw_q    <= '0;
      base_q  <= '0;
      run_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      val_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      bw_q    <= bw_d;
      base_q  <= base_d;
      run_q   <= run_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
    end
  end

  assign oaram_write_enable  = we_q;
  assign oaram_value         = val_q;
  assign oaram_indices_value = idx_q;
  assign oaram_address       = addr_q;
  assign busy                = (state_q != IDLE);
  // The last element's write lands in the FINISH cycle, so done coincides
  // with it and entry_count is already final.
  assign done                = (state_q == FINISH);
  assign entry_count         = count_q;
  assign overflow            = ovf_q;

endmodule

// File: tb/tb_ppu_sparse_encoder.sv
// Self-checking bench: DUT a uses default parameters, DUT b uses RAM_WIDTH=4
// (8-entry OARAM) and shares all inputs, so wrap and overflow are exercised.
module tb_ppu_sparse_encoder;

  localparam int MAXR = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  bitwidth = '0;
  logic        start = 1'b0;
  logic [8:0]  base_address = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;

  logic       in_ready_a, we_a, busy_a, done_a, ovf_a;
  logic [7:0] val_a;
  logic [3:0] idx_a;
  logic [8:0] addr_a;
  logic [9:0] cnt_a;

  logic       in_ready_b, we_b, busy_b, done_b, ovf_b;
  logic [7:0] val_b;
  logic [3:0] idx_b;
  logic [2:0] addr_b;
  logic [3:0] cnt_b;

  ppu_sparse_encoder u_dut_a (
    .clk(clk), .reset_n(reset_n), .bitwidth(bitwidth), .start(start),
    .base_address(base_address), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_last(in_last), .oaram_value(val_a),
    .oaram_indices_value(idx_a), .oaram_address(addr_a),
    .oaram_write_enable(we_a), .busy(busy_a), .done(done_a),
    .entry_count(cnt_a), .overflow(ovf_a)
  );

  ppu_sparse_encoder #(.RAM_WIDTH(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bitwidth(bitwidth), .start(start),
    .base_address(base_address[2:0]), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_last(in_last), .oaram_value(val_b),
    .oaram_indices_value(idx_b), .oaram_address(addr_b),
    .oaram_write_enable(we_b), .busy(busy_b), .done(done_b),
    .entry_count(cnt_b), .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int idx;
    int addr;
    int tag;   // write cycle (captured) or source element index (expected)
  } wr_t;

  int  cyc = 0;
  wr_t got_a[$];
  wr_t got_b[$];
  int  done_n_a = 0, done_n_b = 0;
  int  done_cnt_a = 0, done_cnt_b = 0;
  int  done_ovf_a = 0, done_ovf_b = 0;
  int  zviol = 0;

  int  checks = 0;
  int  errors = 0;

  int  stim[$];
  int  acc[$];
  wr_t exp_q[$];
  wr_t exp_a[$];
  wr_t exp_b[$];
  int  sa, sb, da, db;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive capture of both write ports and done pulses.
  always @(negedge clk) begin
    if (we_a) got_a.push_back('{int'(val_a), int'(idx_a), int'(addr_a), cyc});
    else if (val_a != 0 || idx_a != 0 || addr_a != 0) zviol++;
    if (we_b) got_b.push_back('{int'(val_b), int'(idx_b), int'(addr_b), cyc});
    else if (val_b != 0 || idx_b != 0 || addr_b != 0) zviol++;
    if (done_a) begin done_n_a++; done_cnt_a = int'(cnt_a); done_ovf_a = int'(ovf_a); end
    if (done_b) begin done_n_b++; done_cnt_b = int'(cnt_b); done_ovf_b = int'(ovf_b); end
  end

  // Reference: walk the element list applying ReLU/clip and run-length rules.
  function automatic void model(input int bw, input int base, input int aw,
                                output int cnt, output int ovf);
    int run, cap, q, mx, ev, ei;
    bit emit;
    exp_q.delete();
    run = 0; cnt = 0; ovf = 0;
    cap = 1 << aw;
    mx  = (1 << (8 >> bw)) - 1;
    for (int e = 0; e < stim.size(); e++) begin
      q = (stim[e] < 0) ? 0 : ((stim[e] > mx) ? mx : stim[e]);
      emit = 1'b0;
      if (q != 0) begin emit = 1'b1; ev = q; ei = run; run = 0; end
      else if (run == MAXR) begin emit = 1'b1; ev = 0; ei = MAXR; run = 0; end
      else run++;
      if (emit) begin
        if (cnt == cap) ovf = 1;
        else begin
          exp_q.push_back('{ev, ei, (base + cnt) % cap, e});
          cnt++;
        end
      end
    end
  endfunction

  task automatic gen_stim(input int n);
    int r;
    stim.delete();
    for (int k = 0; k < n; k++) begin
      r = $urandom_range(99);
      if (r < 5) for (int z = 0; z < 16 + $urandom_range(5); z++) stim.push_back(0);
      else if (r < 45) stim.push_back(0);
      else if (r < 60) stim.push_back(-int'($urandom_range(32768, 1)));
      else if (r < 80) stim.push_back(int'($urandom_range(20, 1)));
      else stim.push_back(int'($urandom_range(32767, 1)));
    end
    stim.push_back(int'($urandom_range(400, 1)));
  endtask

  // Start a group and feed stim; optional valid gaps, ignored start pulses
  // and scrambled bitwidth/base while streaming.
  task automatic drive_group(input int bw, input int base, input int gap_pct,
                             input int start_pct, input bit send_last);
    int i, budget;
    sa = got_a.size(); sb = got_b.size(); da = done_n_a; db = done_n_b;
    acc.delete();
    @(posedge clk); #1;
    bitwidth = 2'(bw); base_address = 9'(base); start = 1'b1;
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    i = 0; budget = 0;
    while (i < stim.size() && budget < 4000) begin
      start = ($urandom_range(99) < start_pct);
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0; in_data = 16'($urandom); in_last = 1'($urandom);
      end else begin
        in_valid = 1'b1; in_data = 16'(stim[i]);
        in_last = send_last && (i == stim.size() - 1);
      end
      if (start_pct > 0) begin bitwidth = 2'($urandom); base_address = 9'($urandom); end
      @(negedge clk);
      if (in_valid && in_ready_a) begin acc.push_back(cyc); i++; end
      budget++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
    checks++;
    if (i != stim.size()) begin
      errors++;
      $display("FAIL accept_timeout accepted=%0d required=%0d", i, stim.size());
    end
    if (send_last) repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({we_a, val_a, idx_a, addr_a, busy_a, done_a, cnt_a, ovf_a, in_ready_a} !== '0) begin
      errors++;
      $display("FAIL reset_outputs we=%b v=%0d i=%0d a=%0d busy=%b done=%b cnt=%0d ovf=%b rdy=%b required all 0",
               we_a, val_a, idx_a, addr_a, busy_a, done_a, cnt_a, ovf_a, in_ready_a);
    end
    @(posedge clk); #1;
    reset_n = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy_a=%b busy_b=%b required 0", busy_a, busy_b);
    end
  endtask

  task automatic test_basic();
    stim = '{0, 0, 5, 0, 7};
    drive_group(0, 'h10, 0, 0, 1'b1);
    checks++;
    if (got_a.size() - sa != 2) begin
      errors++;
      $display("FAIL basic_nwrites got=%0d required=2", got_a.size() - sa);
    end else begin
      checks++;
      if (got_a[sa].val !== 5 || got_a[sa].idx !== 2 || got_a[sa].addr !== 'h10) begin
        errors++;
        $display("FAIL basic_w0 got=(%0d,%0d,%0h) required=(5,2,10)",
                 got_a[sa].val, got_a[sa].idx, got_a[sa].addr);
      end
      checks++;
      if (got_a[sa+1].val !== 7 || got_a[sa+1].idx !== 1 || got_a[sa+1].addr !== 'h11) begin
        errors++;
        $display("FAIL basic_w1 got=(%0d,%0d,%0h) required=(7,1,11)",
                 got_a[sa+1].val, got_a[sa+1].idx, got_a[sa+1].addr);
      end
    end
    checks++;
    if (done_n_a - da != 1 || done_cnt_a != 2) begin
      errors++;
      $display("FAIL basic_done pulses=%0d cnt=%0d required 1,2", done_n_a - da, done_cnt_a);
    end
  endtask

  task automatic test_long_zero();
    int b;
    b = int'($urandom_range(500));
    stim.delete();
    for (int k = 0; k < 20; k++) stim.push_back(0);
    stim.push_back(3);
    drive_group(0, b, 0, 0, 1'b1);
    checks++;
    if (got_a.size() - sa != 2) begin
      errors++;
      $display("FAIL zrun_nwrites got=%0d required=2", got_a.size() - sa);
    end else begin
      checks++;
      if (got_a[sa].val !== 0 || got_a[sa].idx !== 15 || got_a[sa].addr !== b ||
          got_a[sa+1].val !== 3 || got_a[sa+1].idx !== 4 || got_a[sa+1].addr !== ((b + 1) % 512)) begin
        errors++;
        $display("FAIL zrun_writes got=(%0d,%0d,%0d)(%0d,%0d,%0d) required=(0,15,%0d)(3,4,%0d)",
                 got_a[sa].val, got_a[sa].idx, got_a[sa].addr,
                 got_a[sa+1].val, got_a[sa+1].idx, got_a[sa+1].addr, b, (b + 1) % 512);
      end
    end
  endtask

  task automatic test_clip();
    stim = '{-5, 200, 9};
    drive_group(1, 0, 0, 0, 1'b1);
    checks++;
    if (got_a.size() - sa != 2) begin
      errors++;
      $display("FAIL clip4_nwrites got=%0d required=2", got_a.size() - sa);
    end else begin
      checks++;
      if (got_a[sa].val !== 15 || got_a[sa].idx !== 1 || got_a[sa+1].val !== 9 || got_a[sa+1].idx !== 0) begin
        errors++;
        $display("FAIL clip4_writes got=(%0d,%0d)(%0d,%0d) required=(15,1)(9,0)",
                 got_a[sa].val, got_a[sa].idx, got_a[sa+1].val, got_a[sa+1].idx);
      end
    end
    stim = '{300};
    drive_group(0, 0, 0, 0, 1'b1);
    checks++;
    if (got_a.size() - sa != 1 || got_a[got_a.size()-1].val !== 255 || got_a[got_a.size()-1].idx !== 0) begin
      errors++;
      $display("FAIL clip8_write nwrites=%0d last_val=%0d required 1 write of 255 idx 0",
               got_a.size() - sa, got_a[got_a.size()-1].val);
    end
  endtask

  task automatic test_overflow();
    int req[8] = '{6, 7, 0, 1, 2, 3, 4, 5};
    stim.delete();
    for (int k = 0; k < 10; k++) stim.push_back(k + 1);
    drive_group(0, 6, 0, 0, 1'b1);
    checks++;
    if (got_b.size() - sb != 8) begin
      errors++;
      $display("FAIL ovf_nwrites got=%0d required=8", got_b.size() - sb);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (got_b[sb+k].addr !== req[k] || got_b[sb+k].val !== k + 1) begin
          errors++;
          $display("FAIL ovf_write%0d got=(%0d@%0d) required=(%0d@%0d)",
                   k, got_b[sb+k].val, got_b[sb+k].addr, k + 1, req[k]);
        end
      end
    end
    checks++;
    if (done_n_b - db != 1 || done_cnt_b != 8 || done_ovf_b != 1 || ovf_b !== 1'b1) begin
      errors++;
      $display("FAIL ovf_status pulses=%0d cnt=%0d ovf_at_done=%0d ovf=%b required 1,8,1,1",
               done_n_b - db, done_cnt_b, done_ovf_b, ovf_b);
    end
    checks++;
    if (got_a.size() - sa != 10 || done_cnt_a != 10 || done_ovf_a != 0) begin
      errors++;
      $display("FAIL ovf_bigram nwrites=%0d cnt=%0d ovf=%0d required 10,10,0",
               got_a.size() - sa, done_cnt_a, done_ovf_a);
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    stim = '{5, 0, 0};
    drive_group(0, 'h40, 0, 0, 1'b0);
    reset_n = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({we_a, val_a, idx_a, addr_a, busy_a, done_a, cnt_a, ovf_a} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs we=%b busy=%b done=%b cnt=%0d required all 0",
               we_a, busy_a, done_a, cnt_a);
    end
    w0 = got_a.size(); d0 = done_n_a;
    @(posedge clk); #1;
    reset_n = 1'b1; start = 1'b0;
    repeat (4) @(posedge clk);
    checks++;
    if (got_a.size() != w0 || done_n_a != d0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet writes=%0d done=%0d busy=%b required 0,0,0",
               got_a.size() - w0, done_n_a - d0, busy_a);
    end
    stim = '{0, 4};
    drive_group(0, 'h40, 0, 0, 1'b1);
    checks++;
    if (got_a.size() - sa != 1 || got_a[sa].val !== 4 || got_a[sa].idx !== 1 || got_a[sa].addr !== 'h40) begin
      errors++;
      $display("FAIL rstmid_restart nwrites=%0d first=(%0d,%0d,%0h) required 1 (4,1,40)",
               got_a.size() - sa, got_a[sa].val, got_a[sa].idx, got_a[sa].addr);
    end
  endtask

  // Same data gapless, then with valid gaps and ignored start pulses.
  task automatic test_gaps();
    wr_t ref_w[$];
    int cnt, ovf;
    gen_stim(30);
    model(2, 'h33, 9, cnt, ovf);
    drive_group(2, 'h33, 0, 0, 1'b1);
    ref_w = got_a[sa:$];
    drive_group(2, 'h33, 40, 20, 1'b1);
    checks++;
    if (got_a.size() - sa != ref_w.size() || ref_w.size() != exp_q.size()) begin
      errors++;
      $display("FAIL gaps_nwrites gapped=%0d gapless=%0d required=%0d",
               got_a.size() - sa, ref_w.size(), exp_q.size());
    end else begin
      for (int k = 0; k < ref_w.size(); k++) begin
        checks++;
        if (got_a[sa+k].val !== exp_q[k].val || got_a[sa+k].idx !== exp_q[k].idx ||
            got_a[sa+k].addr !== exp_q[k].addr || ref_w[k].val !== exp_q[k].val ||
            ref_w[k].idx !== exp_q[k].idx || got_a[sa+k].tag !== acc[exp_q[k].tag] + 1) begin
          errors++;
          $display("FAIL gaps_write%0d gapped=(%0d,%0d,%0d) gapless=(%0d,%0d) required=(%0d,%0d,%0d)",
                   k, got_a[sa+k].val, got_a[sa+k].idx, got_a[sa+k].addr,
                   ref_w[k].val, ref_w[k].idx, exp_q[k].val, exp_q[k].idx, exp_q[k].addr);
        end
      end
    end
    checks++;
    if (done_n_a - da != 1 || done_cnt_a != cnt) begin
      errors++;
      $display("FAIL gaps_done pulses=%0d cnt=%0d required 1,%0d", done_n_a - da, done_cnt_a, cnt);
    end
  endtask

  task automatic test_random();
    int bw, base, cnt_a_m, ovf_a_m, cnt_b_m, ovf_b_m;
    for (int g = 0; g < 12; g++) begin
      gen_stim(int'($urandom_range(40, 1)));
      bw = int'($urandom_range(3));
      base = int'($urandom_range(511));
      model(bw, base, 9, cnt_a_m, ovf_a_m); exp_a = exp_q;
      model(bw, base % 8, 3, cnt_b_m, ovf_b_m); exp_b = exp_q;
      drive_group(bw, base, 25, 10, 1'b1);
      checks++;
      if (got_a.size() - sa != exp_a.size() || got_b.size() - sb != exp_b.size()) begin
        errors++;
        $display("FAIL rand%0d_nwrites a=%0d b=%0d required %0d,%0d",
                 g, got_a.size() - sa, got_b.size() - sb, exp_a.size(), exp_b.size());
      end else begin
        for (int k = 0; k < exp_a.size(); k++) begin
          checks++;
          if (got_a[sa+k].val !== exp_a[k].val || got_a[sa+k].idx !== exp_a[k].idx ||
              got_a[sa+k].addr !== exp_a[k].addr || got_a[sa+k].tag !== acc[exp_a[k].tag] + 1) begin
            errors++;
            $display("FAIL rand%0d_a%0d got=(%0d,%0d,%0d,c%0d) required=(%0d,%0d,%0d,c%0d)",
                     g, k, got_a[sa+k].val, got_a[sa+k].idx, got_a[sa+k].addr, got_a[sa+k].tag,
                     exp_a[k].val, exp_a[k].idx, exp_a[k].addr, acc[exp_a[k].tag] + 1);
          end
        end
        for (int k = 0; k < exp_b.size(); k++) begin
          checks++;
          if (got_b[sb+k].val !== exp_b[k].val || got_b[sb+k].idx !== exp_b[k].idx ||
              got_b[sb+k].addr !== exp_b[k].addr) begin
            errors++;
            $display("FAIL rand%0d_b%0d got=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                     g, k, got_b[sb+k].val, got_b[sb+k].idx, got_b[sb+k].addr,
                     exp_b[k].val, exp_b[k].idx, exp_b[k].addr);
          end
        end
      end
      checks++;
      if (done_n_a - da != 1 || done_cnt_a != cnt_a_m || done_ovf_a != ovf_a_m ||
          done_n_b - db != 1 || done_cnt_b != cnt_b_m || done_ovf_b != ovf_b_m) begin
        errors++;
        $display("FAIL rand%0d_status a(p%0d c%0d o%0d) b(p%0d c%0d o%0d) required a(1 %0d %0d) b(1 %0d %0d)",
                 g, done_n_a - da, done_cnt_a, done_ovf_a, done_n_b - db, done_cnt_b, done_ovf_b,
                 cnt_a_m, ovf_a_m, cnt_b_m, ovf_b_m);
      end
    end
  endtask

  task automatic test_idle_outputs();
    checks++;
    if (zviol != 0) begin
      errors++;
      $display("FAIL quiet_outputs nonzero_outputs_without_we=%0d required 0", zviol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_zero();
    test_clip();
    test_overflow();
    test_reset_mid();
    test_gaps();
    test_random();
    test_idle_outputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
